// File: rtl/multu_seq_ctrl_if.sv
// Handshake/result bundle between the EX/ID pipeline control and the multu sequencer.
interface multu_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             multu_en;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             hilo_rd;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI_q;
    logic [WIDTH-1:0] LO_q;

    modport master (
        output multu_en, op_a, op_b, hilo_rd,
        input  stall, busy, done, HI_q, LO_q
    );

    modport slave (
        input  multu_en, op_a, op_b, hilo_rd,
        output stall, busy, done, HI_q, LO_q
    );
endinterface

// File: rtl/multu_seq_ctrl.sv
// Radix-2 shift-add unsigned multiply sequencer owning HI/LO, with pipeline
// stall generation for hazards on HI/LO and on the busy unit.
module multu_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    multu_seq_ctrl_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   sum;
    logic [CNT_W-1:0] cnt;
    logic             last_step;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             done_q;

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.multu_en) next_state = RUN;
            RUN:     if (last_step) next_state = WRITE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // acc carries one extra bit so mcand + acc never loses its carry.
    always_comb begin
        sum = acc;
        if (mplier[0]) begin
            sum = acc + {1'b0, mcand};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == WRITE);
            case (state)
                IDLE: begin
                    if (bus.multu_en) begin
                        mcand  <= bus.op_a;
                        mplier <= bus.op_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    {acc, mplier} <= {sum, mplier} >> 1;
                    cnt           <= cnt + 1'b1;
                end
                WRITE: begin
                    hi <= acc[WIDTH-1:0];
                    lo <= mplier;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.HI_q  = hi;
    assign bus.LO_q  = lo;
    assign bus.stall = (bus.hilo_rd & (bus.busy | bus.multu_en)) | (bus.multu_en & bus.busy);
endmodule

// File: tb/tb_multu_seq_ctrl.sv
// Self-checking bench for multu_seq_ctrl: vector table plus hand-written
// stall, back-to-back and mid-run reset sequences, with a HI/LO scoreboard.
module tb_multu_seq_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    multu_seq_ctrl_if #(.WIDTH(W)) bus ();

    multu_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse pops the oldest expected product.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 with empty scoreboard, expected no pulse");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_hi", 64'(bus.HI_q), 64'(e.hi));
                check("sb_lo", 64'(bus.LO_q), 64'(e.lo));
            end
        end
    end

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        exp_t e;
        p = 64'(a) * 64'(b);
        e.hi = p[2*W-1:W];
        e.lo = p[W-1:0];
        sb.push_back(e);
        bus.multu_en = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
    endtask

    // Counts edges until done is seen #1 after an edge; also counts busy cycles.
    task automatic wait_done(output int edges, output int busy_n);
        edges  = 0;
        busy_n = 0;
        while (edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.done) return;
            if (bus.busy) busy_n++;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done after %0d edges, expected done", edges);
    endtask

    vec_t vecs[6];

    initial begin
        int edges, busy_n, n, d0;

        bus.multu_en = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.hilo_rd  = 1'b1;

        vecs[0] = '{a: 32'd3,          b: 32'd5,          hi: 32'h0000_0000, lo: 32'h0000_000F};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  hi: 32'hFFFF_FFFE, lo: 32'h0000_0001};
        vecs[2] = '{a: 32'h8000_0000,  b: 32'd2,          hi: 32'h0000_0001, lo: 32'h0000_0000};
        vecs[3] = '{a: 32'h1234_5678,  b: 32'h0000_0000,  hi: 32'h0000_0000, lo: 32'h0000_0000};
        vecs[4] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  hi: 32'h0000_0001, lo: 32'h0000_0000};
        vecs[5] = '{a: 32'hDEAD_BEEF,  b: 32'h0000_0010,  hi: 32'h0000_000D, lo: 32'hEADB_EEF0};

        #12;
        check("rst_hi",    64'(bus.HI_q), 64'h0);
        check("rst_lo",    64'(bus.LO_q), 64'h0);
        check("rst_busy",  64'(bus.busy), 64'h0);
        check("rst_done",  64'(bus.done), 64'h0);
        check("rst_stall", 64'(bus.stall), 64'h0);
        bus.hilo_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven: latency, busy length, done width and the table's own HI/LO.
        foreach (vecs[i]) begin
            start(vecs[i].a, vecs[i].b);
            @(posedge clk);
            #1;
            bus.multu_en = 1'b0;
            check("busy_after_accept", 64'(bus.busy), 64'h1);
            wait_done(edges, busy_n);
            check("latency_edges", 64'(edges), 64'(W + 1));
            check("busy_cycles", 64'(busy_n + 1), 64'(W + 1));
            check("vec_hi", 64'(bus.HI_q), 64'(vecs[i].hi));
            check("vec_lo", 64'(bus.LO_q), 64'(vecs[i].lo));
            @(posedge clk);
            #1;
            check("done_one_cycle", 64'(bus.done), 64'h0);
            repeat (3) @(posedge clk);
            #1;
            check("hold_lo", 64'(bus.LO_q), 64'(vecs[i].lo));
        end

        // mfhi/mflo directly behind a multu: stall spans EX cycle through WRITE.
        for (int k = 0; k < 2; k++) begin
            bus.hilo_rd = 1'b1;
            start(32'h0000_BEEF, (k == 0) ? 32'd0 : 32'd7);
            n = 0;
            while (n < 200) begin
                @(negedge clk);
                if (!bus.stall) break;
                n++;
                @(posedge clk);
                #1;
                bus.multu_en = 1'b0;
            end
            check("stall_len", 64'(n), 64'(W + 2));
            check("done_at_release", 64'(bus.done), 64'h1);
            bus.hilo_rd = 1'b0;
            @(posedge clk);
            #1;
        end
        check("opb0_result_hi", 64'(bus.HI_q), 64'h0);

        // Back-to-back: second multu held in EX while busy.
        d0 = done_cnt;
        start(32'd7, 32'd9);
        @(posedge clk);
        #1;
        start(32'd6, 32'd4);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (bus.done) break;
            if (bus.stall) n++;
        end
        check("b2b_stall_cycles", 64'(n), 64'(W + 1));
        check("b2b_stall_low_done", 64'(bus.stall), 64'h0);
        check("b2b_first_lo", 64'(bus.LO_q), 64'h3F);
        @(posedge clk);
        #1;
        bus.multu_en = 1'b0;
        check("b2b_second_busy", 64'(bus.busy), 64'h1);
        wait_done(edges, busy_n);
        check("b2b_final_lo", 64'(bus.LO_q), 64'h18);
        @(posedge clk);
        #1;
        check("b2b_done_pulses", 64'(done_cnt - d0), 64'd2);

        // Mid-run asynchronous reset abandons the multiply.
        start(32'd7, 32'd9);
        @(posedge clk);
        #1;
        bus.multu_en = 1'b0;
        wait_done(edges, busy_n);
        check("pre_rst_lo", 64'(bus.LO_q), 64'h3F);
        @(posedge clk);
        #1;
        start(32'h1234, 32'h10);
        @(posedge clk);
        #1;
        bus.multu_en = 1'b0;
        bus.hilo_rd  = 1'b1;
        repeat (9) @(posedge clk);
        #2;
        d0 = done_cnt;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_hi",    64'(bus.HI_q), 64'h0);
        check("arst_lo",    64'(bus.LO_q), 64'h0);
        check("arst_busy",  64'(bus.busy), 64'h0);
        check("arst_stall", 64'(bus.stall), 64'h0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        bus.hilo_rd = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
        check("arst_no_done", 64'(done_cnt - d0), 64'd0);
        check("arst_lo_held", 64'(bus.LO_q), 64'h0);
        start(32'd2, 32'd2);
        @(posedge clk);
        #1;
        bus.multu_en = 1'b0;
        wait_done(edges, busy_n);
        check("post_rst_lo", 64'(bus.LO_q), 64'h4);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multu_seq_ctrl.md
Name: multu_seq_ctrl

Overview:
- Multi-cycle sequencer for the unsigned multiply resource and the HI/LO register pair in the 5-stage pipeline.
- Accepts a multu issued from the EX stage and runs a radix-2 shift-add multiply over WIDTH cycles.
- Writes the result into HI_q/LO_q. These outputs feed the ID stage as HI_qD/LO_qD.
- Generates the stall that freezes PC, IF/ID and ID/EX while a younger mfhi/mflo or a second multu would see stale HI/LO or find the unit busy.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH (HI = upper WIDTH, LO = lower WIDTH).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- multu_en  input  1  multu present in EX stage (multu_enE).
- op_a  input  WIDTH  multiplicand (rs value in EX).
- op_b  input  WIDTH  multiplier (rt value in EX).
- hilo_rd  input  1  instruction in ID reads HI or LO (mfhi/mflo).
- stall  output  1  combinational; freeze PC, IF/ID, ID/EX this cycle.
- busy  output  1  multiply in progress (state != IDLE).
- done  output  1  registered one-cycle pulse; HI_q/LO_q just updated.
- HI_q  output  WIDTH  HI register.
- LO_q  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; HI_q=0, LO_q=0; done=0; busy=0.
  - Internal multiplicand, accumulator and counter cleared.
  - An in-flight multiply is abandoned; HI/LO are not written.
- States: IDLE, RUN, WRITE.
- IDLE:
  - If multu_en=1, at the edge: latch mcand=op_a, mplier=op_b, acc=0 (WIDTH+1 bits), cnt=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - If mplier[0]=1: sum = acc + {1'b0, mcand} (WIDTH+1 bits, carry kept); else sum = acc.
  - Shift {sum, mplier} right by 1 into {acc, mplier}.
  - cnt increments; when cnt = WIDTH-1 at the edge, go to WRITE.
  - RUN lasts exactly WIDTH cycles.
  - No early termination: op_b=0 still takes the full WIDTH cycles.
- WRITE, at the edge: HI_q = acc[WIDTH-1:0]; LO_q = mplier; done=1 in the following cycle; go to IDLE.
- done:
  - High for exactly one cycle, the first IDLE cycle after WRITE.
  - Otherwise 0. Not asserted after reset.
- Latency: multu accepted at edge E0 → HI_q/LO_q updated at edge E0+WIDTH+1.
- stall = (hilo_rd & (busy | multu_en)) | (multu_en & busy).
  - mfhi/mflo directly behind a multu stalls from the multu's EX cycle through the WRITE cycle: WIDTH+2 cycles total. It then reads the new HI_q/LO_q in ID.
  - A second multu reaching EX while busy is held via stall. It is accepted in the IDLE cycle after WRITE, where stall is low for it.
- busy=1 in RUN and WRITE, 0 in IDLE.
- HI_q/LO_q change only at the WRITE edge or on reset. They hold their value indefinitely otherwise.
- multu_en while not IDLE never disturbs the operation in progress.
- Arithmetic is unsigned. The carry bit of acc is required: max × max must not overflow.

Test Plan:
- Reset, then multu_en=1 for one cycle with op_a=3, op_b=5 → busy=1 for 33 cycles; done pulses one cycle; HI_q=0x00000000, LO_q=0x0000000F at E0+33.
- op_a=op_b=0xFFFFFFFF → HI_q=0xFFFFFFFE, LO_q=0x00000001. Also op_a=0x80000000, op_b=2 → HI_q=1, LO_q=0.
- hilo_rd=1 held in the cycle multu_en=1 and onward → stall high for exactly 34 consecutive cycles, low in the done cycle; op_b=0 case gives the same stall count and HI/LO = 0.
- Back-to-back: 7*9, then a second multu (6*4) held in EX with multu_en=1 while busy → stall high until the first done; second accepted next cycle; final LO_q=0x18 with exactly two done pulses. LO_q=0x3F is visible between the two done pulses.
- Reset: after one 7*9 completes (LO_q=0x3F), start 0x1234*0x10 and pull rst_n low at RUN cycle 10 → HI_q/LO_q=0, busy=0, stall=0 immediately (asynchronously); no done pulse; a new 2*2 afterwards yields LO_q=4.
